// File: rtl/imem_cache_ctrl.sv
// Direct-mapped instruction cache between IF and the memory controller: 1-cycle hit path, line refill as a counted word stream.
// Optional IMEM_PERF_CNT_EN adds saturating hit/miss counters (perf_hits, perf_misses).
module imem_cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OFF_W  = 10,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_valid,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              refill_req,
  output logic [ADDR_W-1:0] refill_base,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data
`ifdef IMEM_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hits,
  output logic [31:0]       perf_misses
`endif
);

  localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
  localparam int LINES      = 2 ** IDX_W;
  localparam int LINE_WORDS = 2 ** OFF_W;
  localparam int RAM_AW     = OFF_W + IDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REFILL = 2'd2;
  localparam logic [1:0] S_REPLAY = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_r;
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [LINES-1:0]  valid_q;
  logic [OFF_W-1:0]  cnt;
  logic              flush_pend;
  logic              replay_out;
  logic [DATA_W-1:0] ram [LINES*LINE_WORDS];
  logic [DATA_W-1:0] ram_q;

  logic [TAG_W-1:0]  tag_r;
  logic [IDX_W-1:0]  idx_r;
  logic              hit, miss, accept, last_beat, ram_we, ram_re;
  logic [RAM_AW-1:0] ram_raddr;

  assign tag_r = addr_r[ADDR_W-1:OFF_W+IDX_W];
  assign idx_r = addr_r[OFF_W+IDX_W-1:OFF_W];

  // A flush in the lookup cycle wins over the stored valid bit.
  assign hit       = (state == S_LOOKUP) && valid_q[idx_r] && (tag_q[idx_r] == tag_r) && !flush;
  assign miss      = (state == S_LOOKUP) && !hit;
  assign accept    = cpu_req && ((state == S_IDLE) || hit);
  assign ram_we    = (state == S_REFILL) && fill_valid;
  assign last_beat = ram_we && (cnt == OFF_W'(LINE_WORDS - 1));
  assign ram_re    = accept || (state == S_REPLAY);
  assign ram_raddr = (state == S_REPLAY) ? addr_r[RAM_AW-1:0] : cpu_addr[RAM_AW-1:0];

  assign cpu_valid = hit || replay_out;
  assign cpu_stall = miss || (state == S_REFILL) || (state == S_REPLAY);
  assign cpu_rdata = ram_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram[{idx_r, cnt}] <= fill_data;
    if (ram_re) ram_q <= ram[ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (last_beat) tag_q[idx_r] <= tag_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      addr_r      <= '0;
      valid_q     <= '0;
      cnt         <= '0;
      flush_pend  <= 1'b0;
      replay_out  <= 1'b0;
      refill_req  <= 1'b0;
      refill_base <= '0;
    end else begin
      replay_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_r <= cpu_addr;
            state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            if (cpu_req) addr_r <= cpu_addr;
            else         state  <= S_IDLE;
          end else begin
            state       <= S_REFILL;
            refill_req  <= 1'b1;
            refill_base <= {tag_r, idx_r, {OFF_W{1'b0}}};
          end
        end
        S_REFILL: begin
          if (fill_valid) cnt <= cnt + 1'b1;
          if (last_beat) begin
            state      <= S_REPLAY;
            refill_req <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          replay_out <= 1'b1;
        end
      endcase

      if (last_beat)                           flush_pend <= 1'b0;
      else if (flush && (state == S_REFILL))   flush_pend <= 1'b1;

      // Later assignments override: flush, then miss invalidate, then install.
      if (flush)     valid_q        <= '0;
      if (miss)      valid_q[idx_r] <= 1'b0;
      if (last_beat) valid_q[idx_r] <= !(flush_pend || flush);
    end
  end

`ifdef IMEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (hit  && (perf_hits   != 32'hFFFF_FFFF)) perf_hits   <= perf_hits + 32'd1;
      if (miss && (perf_misses != 32'hFFFF_FFFF)) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_cache_ctrl.sv
// Directed bench for imem_cache_ctrl: cold miss, hit stream, eviction, gapped fill, flush and reset cases.
module tb_imem_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_valid, cpu_stall;
  logic        flush = 1'b0;
  logic        refill_req;
  logic [31:0] refill_base;
  logic        fill_valid = 1'b0;
  logic [31:0] fill_data = '0;
`ifdef IMEM_PERF_CNT_EN
  logic [31:0] perf_hits, perf_misses;
`endif

  int total = 0;
  int bad   = 0;

  imem_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_stall(cpu_stall),
    .flush(flush), .refill_req(refill_req), .refill_base(refill_base),
    .fill_valid(fill_valid), .fill_data(fill_data)
`ifdef IMEM_PERF_CNT_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fetch addr, expect a miss, stream the line (word = salt ^ word address),
  // optionally flush at one beat or stop early at abort_at beats.
  task automatic refill(input logic [31:0] addr, input logic [31:0] salt, input bit gapped,
                        input int flush_beat, input int abort_at);
    logic [31:0] base;
    int t, i, k;
    base = {addr[31:10], 10'b0};
    @(negedge clk); cpu_req = 1'b1; cpu_addr = addr;
    @(negedge clk); #1;
    chk("miss_lookup", {30'b0, cpu_stall, cpu_valid}, 32'b10);
    t = 0;
    while (!refill_req && t < 8) begin @(negedge clk); #1; t++; end
    chk("refill_req_rise", {31'b0, refill_req}, 32'd1);
    chk("refill_base", refill_base, base);
    i = 0; k = 0;
    while (i < 1024 && i != abort_at) begin
      fill_valid = gapped ? (k % 3 == 0) : 1'b1;
      fill_data  = salt ^ (base + 32'(i));
      flush      = fill_valid && (i == flush_beat);
      @(negedge clk); #1;
      if (fill_valid) i++;
      k++;
      if (k == 5) chk("refill_hold", {29'b0, refill_req, cpu_stall, cpu_valid}, 32'b110);
    end
    fill_valid = 1'b0; flush = 1'b0;
    if (i != abort_at) begin
      t = 0;
      while (!cpu_valid && t < 8) begin @(negedge clk); #1; t++; end
      cpu_req = 1'b0;
      chk("replay_valid", {31'b0, cpu_valid}, 32'd1);
      chk("replay_rdata", cpu_rdata, salt ^ addr);
      @(negedge clk); #1;
      chk("after_replay", {29'b0, cpu_valid, cpu_stall, refill_req}, 32'b000);
    end
  endtask

  // Back-to-back fetches of n consecutive words from start; all must hit.
  task automatic hits(input logic [31:0] start, input int n, input logic [31:0] salt);
    @(negedge clk); cpu_req = 1'b1; cpu_addr = start;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk("hit_flags", {30'b0, cpu_valid, cpu_stall}, 32'b10);
      chk("hit_rdata", cpu_rdata, salt ^ (start + 32'(i)));
      if (i < n - 1) cpu_addr = start + 32'(i + 1);
      else           cpu_req = 1'b0;
    end
  endtask

  initial begin
    #2;
    chk("rst_outputs", {29'b0, refill_req, cpu_valid, cpu_stall}, 32'b000);
    chk("rst_base", refill_base, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // cold miss, then hit stream
    refill(32'h0000_0405, 32'h0, 1'b0, -1, -1);
    hits(32'h0000_0400, 16, 32'h0);
`ifdef IMEM_PERF_CNT_EN
    chk("perf_misses", perf_misses, 32'd1);
    chk("perf_hits", perf_hits, 32'd16);
`endif

    // conflict eviction, then gapped refill of the evicted line and full readback
    refill(32'h0000_1405, 32'h0, 1'b0, -1, -1);
    refill(32'h0000_0405, 32'hA5A5_0000, 1'b1, -1, -1);
    hits(32'h0000_0400, 1024, 32'hA5A5_0000);

    // flush in idle, then flush during a refill leaves the line invalid
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    refill(32'h0000_0405, 32'h1111_0000, 1'b0, 500, -1);
    refill(32'h0000_0405, 32'h3333_0000, 1'b0, -1, -1);
    hits(32'h0000_0405, 1, 32'h3333_0000);

    // reset in the middle of a refill
    refill(32'h0000_1805, 32'h0, 1'b0, -1, 300);
    rst = 1'b0; #1;
    chk("rst_mid_refill", {29'b0, refill_req, cpu_stall, cpu_valid}, 32'b000);
    cpu_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    refill(32'h0000_0405, 32'h4444_0000, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
